// File: rtl/apb_regs_pkg.sv
// apb_regs_pkg: shared types for the APB register bank.
//   access_mode_e : per-register access behaviour (RW, RO passthrough, W1C)
//   wait_state_e  : states of the pready wait generator
//   apb_req_t     : APB4 request  (psel, penable, pwrite, paddr, pwdata, pstrb, pprot)
//   apb_resp_t    : APB4 response (pready, prdata, pslverr)
package apb_regs_pkg;

   typedef enum logic [1:0] {
      ACC_RW  = 2'd0,
      ACC_RO  = 2'd1,
      ACC_W1C = 2'd2
   } access_mode_e;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_WAIT = 1'b1
   } wait_state_e;

   localparam int MaxWaitCycles = 15;

   // Widest supported bus; narrower configurations use the low bits.
   typedef struct packed {
      logic        psel;
      logic        penable;
      logic        pwrite;
      logic [31:0] paddr;
      logic [31:0] pwdata;
      logic [3:0]  pstrb;
      logic [2:0]  pprot;
   } apb_req_t;

   typedef struct packed {
      logic        pready;
      logic [31:0] prdata;
      logic        pslverr;
   } apb_resp_t;

endpackage

// File: rtl/apb_regs_hw_wait_gen.sv
// apb_wait_gen: inserts WaitCycles extra access-phase cycles before pready.
//   clk, rst_n     : clock, asynchronous active-low reset
//   psel, penable  : APB handshake inputs
//   pready         : completes the access
//   commit         : the single cycle in which the access takes effect
module apb_wait_gen
   import apb_regs_pkg::*;
#(
   parameter int WaitCycles = 0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic psel,
   input  logic penable,
   output logic pready,
   output logic commit
);

   if (WaitCycles < 0 || WaitCycles > MaxWaitCycles) begin : g_bad_wait
      $fatal(1, "apb_wait_gen: WaitCycles out of range");
   end

   localparam logic [3:0] WaitCnt = 4'(WaitCycles);

   wait_state_e state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= 4'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      pready  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (psel && penable) begin
               if (WaitCycles == 0) begin
                  pready = 1'b1;
               end else begin
                  state_d = ST_WAIT;
                  cnt_d   = 4'd1;
               end
            end
         end
         ST_WAIT: begin
            // Master abandoned the transfer: drop it without completing.
            if (!psel) begin
               state_d = ST_IDLE;
               cnt_d   = 4'd0;
            end else if (cnt_q == WaitCnt) begin
               pready  = 1'b1;
               state_d = ST_IDLE;
               cnt_d   = 4'd0;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = 4'd0;
         end
      endcase
   end

   assign commit = pready & psel & penable;

endmodule

// File: rtl/apb_regs_hw.sv
// apb_regs_hw: APB4 control/status register bank with hardware update ports.
//   pclk_i, preset_ni : clock, asynchronous active-low reset
//   req_i / resp_o    : APB4 slave port
//   base_addr_i       : byte address of register 0
//   reg_init_i        : values presented by read-only registers
//   hw_we_i, hw_d_i   : hardware load of RW registers (wins over APB writes)
//   hw_set_i          : per-bit set events for W1C registers (wins over clears)
//   reg_q_o           : current register contents
//   reg_wr_pulse_o    : one-cycle pulse per register on a committed APB write
//   reg_rd_pulse_o    : one-cycle pulse per register on a committed APB read
//   irq_o             : OR of every bit held in W1C registers
module apb_regs_hw
   import apb_regs_pkg::*;
#(
   parameter int NoApbRegs    = 4,
   parameter int ApbAddrWidth = 32,
   parameter int AddrOffset   = 4,
   parameter int ApbDataWidth = 32,
   parameter int RegDataWidth = 32,
   parameter access_mode_e [NoApbRegs-1:0] AccessMode = '{default: ACC_RW},
   parameter int WaitCycles   = 0,
   parameter type req_t       = apb_req_t,
   parameter type resp_t      = apb_resp_t
) (
   input  logic                              pclk_i,
   input  logic                              preset_ni,
   input  req_t                              req_i,
   output resp_t                             resp_o,
   input  logic [ApbAddrWidth-1:0]           base_addr_i,
   input  logic [NoApbRegs*RegDataWidth-1:0] reg_init_i,
   input  logic [NoApbRegs-1:0]              hw_we_i,
   input  logic [NoApbRegs*RegDataWidth-1:0] hw_d_i,
   input  logic [NoApbRegs*RegDataWidth-1:0] hw_set_i,
   output logic [NoApbRegs*RegDataWidth-1:0] reg_q_o,
   output logic [NoApbRegs-1:0]              reg_wr_pulse_o,
   output logic [NoApbRegs-1:0]              reg_rd_pulse_o,
   output logic                              irq_o
);

   localparam int W       = RegDataWidth;
   localparam int NumStrb = (ApbDataWidth + 7) / 8;
   // Each register decodes only its first data word; the rest of the
   // AddrOffset stride is a gap that answers with an error.
   localparam int RegBytes = 4;

   // ---------------- address decode ----------------
   function automatic logic [NoApbRegs-1:0] addr_decode(input logic [ApbAddrWidth-1:0] offs);
      logic [NoApbRegs-1:0] h;
      h = '0;
      for (int i = 0; i < NoApbRegs; i++) begin
         h[i] = (offs >= ApbAddrWidth'(i * AddrOffset)) &&
                (offs <  ApbAddrWidth'(i * AddrOffset + RegBytes));
      end
      return h;
   endfunction

   logic [ApbAddrWidth-1:0] offs;
   logic [NoApbRegs-1:0]    hit;
   logic [NoApbRegs-1:0]    ro_mask;
   logic [NumStrb-1:0]      strb;
   logic [W-1:0]            wdata, wmask, rdata;
   logic                    pready, commit, dec_err, err, wr_ok, rd_ok;

   // Address below the base wraps to a huge offset and misses every span.
   assign offs    = req_i.paddr[ApbAddrWidth-1:0] - base_addr_i;
   assign hit     = addr_decode(offs);
   assign dec_err = ~|hit;
   assign strb    = req_i.pstrb[NumStrb-1:0];
   assign wdata   = req_i.pwdata[W-1:0];

   always_comb begin
      wmask = '0;
      for (int b = 0; b < W; b++) wmask[b] = strb[b / 8];
   end

   // ---------------- handshake ----------------
   apb_wait_gen #(.WaitCycles(WaitCycles)) u_wait (
      .clk     (pclk_i),
      .rst_n   (preset_ni),
      .psel    (req_i.psel),
      .penable (req_i.penable),
      .pready  (pready),
      .commit  (commit)
   );

   assign err   = dec_err | (req_i.pwrite & ((|(hit & ro_mask)) | (strb == '0)));
   assign wr_ok = commit &  req_i.pwrite & ~err;
   assign rd_ok = commit & ~req_i.pwrite & ~err;

   assign reg_wr_pulse_o = {NoApbRegs{wr_ok}} & hit;
   assign reg_rd_pulse_o = {NoApbRegs{rd_ok}} & hit;

   // ---------------- registers ----------------
   logic [NoApbRegs-1:0] irq_vec;

   for (genvar i = 0; i < NoApbRegs; i++) begin : g_reg
      if (AccessMode[i] != ACC_RW && AccessMode[i] != ACC_RO && AccessMode[i] != ACC_W1C) begin : g_bad_mode
         $fatal(1, "apb_regs_hw: reserved access mode");
      end

      assign ro_mask[i] = (AccessMode[i] == ACC_RO);

      if (AccessMode[i] == ACC_RO) begin : g_ro
         assign reg_q_o[i*W +: W] = reg_init_i[i*W +: W];
         assign irq_vec[i]        = 1'b0;
      end else begin : g_flop
         logic [W-1:0] q, d;

         always_comb begin
            d = q;
            if (AccessMode[i] == ACC_RW) begin
               if (hw_we_i[i])             d = hw_d_i[i*W +: W];
               else if (reg_wr_pulse_o[i]) d = (q & ~wmask) | (wdata & wmask);
            end else begin
               // Set applied after the clear so a simultaneous set wins.
               d = q & ~(reg_wr_pulse_o[i] ? (wdata & wmask) : '0);
               d = d | hw_set_i[i*W +: W];
            end
         end

         always_ff @(posedge pclk_i or negedge preset_ni) begin
            if (!preset_ni) q <= '0;
            else            q <= d;
         end

         assign reg_q_o[i*W +: W] = q;
         assign irq_vec[i]        = (AccessMode[i] == ACC_W1C) ? |q : 1'b0;
      end
   end

   assign irq_o = |irq_vec;

   // ---------------- read data / response ----------------
   always_comb begin
      rdata = '0;
      for (int i = 0; i < NoApbRegs; i++) begin
         if (hit[i]) rdata = rdata | reg_q_o[i*W +: W];
      end
   end

   always_comb begin
      resp_o         = '0;
      resp_o.pready  = pready;
      resp_o.pslverr = commit & err;
      if (rd_ok) resp_o.prdata[W-1:0] = rdata;
   end

   // Bits consumed only for some access modes or widths.
   logic unused_bits;
   assign unused_bits = ^{req_i, hw_we_i, hw_d_i, hw_set_i, reg_init_i};

endmodule

// File: tb/tb_apb_regs_hw.sv
// tb_apb_regs_hw: scoreboard bench for apb_regs_hw.
// dut_a: WaitCycles=0, AddrOffset=4; dut_b: WaitCycles=3, AddrOffset=8.
// Register map on both: 0,1 RW, 2 W1C, 3 RO.
module tb_apb_regs_hw;
   import apb_regs_pkg::*;

   localparam int N  = 4;
   localparam int DW = 32;
   localparam access_mode_e [N-1:0] MODES = '{ACC_RO, ACC_W1C, ACC_RW, ACC_RW};

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic              rst_a, rst_b;
   apb_req_t          req   [2];
   apb_resp_t         resp  [2];
   logic [31:0]       base  [2];
   logic [N*DW-1:0]   init  [2];
   logic [N*DW-1:0]   hw_d  [2];
   logic [N*DW-1:0]   hw_set[2];
   logic [N*DW-1:0]   q     [2];
   logic [N-1:0]      hw_we [2];
   logic [N-1:0]      wp    [2];
   logic [N-1:0]      rp    [2];
   logic              irq   [2];

   apb_regs_hw #(.NoApbRegs(N), .AddrOffset(4), .AccessMode(MODES), .WaitCycles(0)) dut_a (
      .pclk_i(clk), .preset_ni(rst_a), .req_i(req[0]), .resp_o(resp[0]),
      .base_addr_i(base[0]), .reg_init_i(init[0]), .hw_we_i(hw_we[0]), .hw_d_i(hw_d[0]),
      .hw_set_i(hw_set[0]), .reg_q_o(q[0]), .reg_wr_pulse_o(wp[0]), .reg_rd_pulse_o(rp[0]),
      .irq_o(irq[0]));

   apb_regs_hw #(.NoApbRegs(N), .AddrOffset(8), .AccessMode(MODES), .WaitCycles(3)) dut_b (
      .pclk_i(clk), .preset_ni(rst_b), .req_i(req[1]), .resp_o(resp[1]),
      .base_addr_i(base[1]), .reg_init_i(init[1]), .hw_we_i(hw_we[1]), .hw_d_i(hw_d[1]),
      .hw_set_i(hw_set[1]), .reg_q_o(q[1]), .reg_wr_pulse_o(wp[1]), .reg_rd_pulse_o(rp[1]),
      .irq_o(irq[1]));

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      logic [3:0]  wp;
      logic [3:0]  rp;
   } exp_t;

   exp_t sb0[$];
   exp_t sb1[$];
   exp_t mon_e;
   bit   mon_have;
   int   n_chk  = 0;
   int   n_pass = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
   endtask

   // Monitor: completion cycles are matched against the scoreboard,
   // every other cycle must show a quiet response and no pulses.
   always @(negedge clk) begin
      for (int d = 0; d < 2; d++) begin
         if (resp[d].pready) begin
            mon_have = 1'b0;
            if (d == 0 && sb0.size() > 0) begin mon_e = sb0.pop_front(); mon_have = 1'b1; end
            if (d == 1 && sb1.size() > 0) begin mon_e = sb1.pop_front(); mon_have = 1'b1; end
            if (!mon_have) chk($sformatf("unexpected_pready_%0d", d), 1, 0);
            else begin
               chk($sformatf("prdata_%0d", d), resp[d].prdata, mon_e.rdata);
               chk($sformatf("pslverr_%0d", d), resp[d].pslverr, mon_e.err);
               chk($sformatf("pulses_%0d", d), {wp[d], rp[d]}, {mon_e.wp, mon_e.rp});
            end
         end else begin
            chk($sformatf("idle_quiet_%0d", d), {resp[d].prdata, resp[d].pslverr, wp[d], rp[d]}, 0);
         end
      end
   end

   // One APB transfer: pushes its expected response, checks the pready latency.
   task automatic xfer(input int d, input bit wr, input logic [31:0] addr, input logic [31:0] wd,
                       input logic [3:0] strb, input logic [31:0] er, input bit ee,
                       input logic [3:0] ewp, input logic [3:0] erp, input int elat);
      exp_t e;
      int   lat;
      bit   done;
      e.rdata = er; e.err = ee; e.wp = ewp; e.rp = erp;
      if (d == 0) sb0.push_back(e); else sb1.push_back(e);
      @(posedge clk); #1;
      req[d].psel = 1'b1; req[d].penable = 1'b0; req[d].pwrite = wr;
      req[d].paddr = addr; req[d].pwdata = wd; req[d].pstrb = strb; req[d].pprot = 3'd0;
      @(posedge clk); #1;
      req[d].penable = 1'b1;
      lat = 0; done = 1'b0;
      while (!done && lat < 40) begin
         @(negedge clk);
         lat++;
         if (resp[d].pready) done = 1'b1;
         else begin @(posedge clk); #1; end
      end
      chk($sformatf("latency_%0d_%0h", d, addr), lat, elat);
      @(posedge clk); #1;
      req[d] = '0;
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_a = 1'b0; rst_b = 1'b0;
      req[0] = '0; req[1] = '0;
      base[0] = 32'h4000_0000; base[1] = 32'h8000_1000;
      init[0] = '0; init[1] = '0;
      init[0][127:96] = 32'hA5A5_A5A5;
      hw_d[0] = '0; hw_d[1] = '0; hw_set[0] = '0; hw_set[1] = '0;
      hw_we[0] = '0; hw_we[1] = '0;

      // reset state
      repeat (2) @(posedge clk);
      #1;
      chk("rst_q_a_lo", q[0][63:0], 0);
      chk("rst_q_a_w1c", q[0][95:64], 0);
      chk("rst_q_a_ro", q[0][127:96], 32'hA5A5_A5A5);
      chk("rst_irq_a", irq[0], 0);
      chk("rst_q_b", q[1][63:0], 0);
      rst_a = 1'b1; rst_b = 1'b1;

      // RW byte-strobed writes, hardware override, read back
      xfer(0, 1, 32'h4000_0000, 32'hDEAD_BEEF, 4'b0011, 0, 0, 4'b0001, 0, 1);
      chk("rw_strb_lo", q[0][31:0], 32'h0000_BEEF);
      xfer(0, 1, 32'h4000_0000, 32'h1234_5678, 4'b1100, 0, 0, 4'b0001, 0, 1);
      chk("rw_strb_hi", q[0][31:0], 32'h1234_BEEF);
      hw_we[0] = 4'b0001; hw_d[0][31:0] = 32'hCAFE_F00D;
      xfer(0, 1, 32'h4000_0000, 32'hFFFF_FFFF, 4'b1111, 0, 0, 4'b0001, 0, 1);
      hw_we[0] = '0;
      chk("rw_hw_override", q[0][31:0], 32'hCAFE_F00D);
      xfer(0, 0, 32'h4000_0000, 0, 4'b1111, 32'hCAFE_F00D, 0, 0, 4'b0001, 1);

      // W1C: hardware set, clear with simultaneous set, full clear
      hw_set[0][95:64] = 32'hF;
      @(posedge clk); #1;
      hw_set[0] = '0;
      chk("w1c_set", q[0][95:64], 32'hF);
      chk("irq_rise", irq[0], 1);
      hw_set[0][95:64] = 32'h1;
      xfer(0, 1, 32'h4000_0008, 32'h5, 4'b1111, 0, 0, 4'b0100, 0, 1);
      hw_set[0] = '0;
      chk("w1c_set_wins", q[0][95:64], 32'hB);
      chk("irq_held", irq[0], 1);
      xfer(0, 0, 32'h4000_0008, 0, 4'b1111, 32'hB, 0, 0, 4'b0100, 1);
      xfer(0, 1, 32'h4000_0008, 32'hB, 4'b1111, 0, 0, 4'b0100, 0, 1);
      chk("w1c_clear", q[0][95:64], 0);
      chk("irq_fall", irq[0], 0);

      // RO passthrough
      xfer(0, 0, 32'h4000_000C, 0, 4'b1111, 32'hA5A5_A5A5, 0, 0, 4'b1000, 1);
      xfer(0, 1, 32'h4000_000C, 32'h0, 4'b1111, 0, 1, 0, 0, 1);
      chk("ro_unchanged", q[0][127:96], 32'hA5A5_A5A5);

      // errors: past last register, below base, zero strobe
      xfer(0, 0, 32'h4000_0010, 0, 4'b1111, 0, 1, 0, 0, 1);
      xfer(0, 0, 32'h3FFF_FFFC, 0, 4'b1111, 0, 1, 0, 0, 1);
      xfer(0, 1, 32'h4000_0000, 32'h0, 4'b0000, 0, 1, 0, 0, 1);
      chk("zero_strb_nochange", q[0][31:0], 32'hCAFE_F00D);

      // wait states and stride gaps on dut_b
      xfer(1, 1, 32'h8000_1008, 32'h1234_5678, 4'b1111, 0, 0, 4'b0010, 0, 4);
      chk("b_reg1", q[1][63:32], 32'h1234_5678);
      xfer(1, 0, 32'h8000_1008, 0, 4'b1111, 32'h1234_5678, 0, 0, 4'b0010, 4);
      xfer(1, 0, 32'h8000_1004, 0, 4'b1111, 0, 1, 0, 0, 4);

      // reset during the second wait cycle drops the write
      @(posedge clk); #1;
      req[1].psel = 1'b1; req[1].pwrite = 1'b1; req[1].paddr = 32'h8000_1000;
      req[1].pwdata = 32'h99; req[1].pstrb = 4'b1111;
      @(posedge clk); #1;
      req[1].penable = 1'b1;
      @(posedge clk);
      @(posedge clk); #1;
      rst_b = 1'b0;
      #1 req[1] = '0;
      @(posedge clk); #1;
      rst_b = 1'b1;
      chk("midwait_reg0", q[1][31:0], 0);
      chk("midwait_reg1", q[1][63:32], 0);
      xfer(1, 1, 32'h8000_1000, 32'h77, 4'b1111, 0, 0, 4'b0001, 0, 4);
      chk("after_reset_write", q[1][31:0], 32'h77);

      repeat (2) @(posedge clk);
      #1;
      chk("sb_drained", sb0.size() + sb1.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
